// File: rtl/z80_daisy_intc.sv
`default_nettype none
// ============================================================================
// Module   : z80_daisy_intc
// Brief    : Z80 mode-2 daisy-chain interrupt controller with IEI/IEO chaining
//            and RETI (ED 4D) decode from the opcode-fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
module z80_daisy_intc #(
    parameter int         NCH        = 4,
    parameter logic [7:0] VEC_BASE   = 8'h00,
    parameter int         VEC_STRIDE = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [7:0]     DI,
    input  logic           M1_n,
    input  logic           IORQ_n,
    input  logic           RD_n,
    input  logic           IEI,
    output logic           IEO,
    output logic           INT_n,
    output logic           VEC_OE,
    output logic [7:0]     VEC_DO,
    input  logic [NCH-1:0] INTI,
    input  logic [NCH-1:0] INTEN,
    output logic [NCH-1:0] IUS
);

    localparam logic [7:0] c_OP_ED = 8'hED;
    localparam logic [7:0] c_OP_CB = 8'hCB;
    localparam logic [7:0] c_OP_4D = 8'h4D;

    // Registered copies of the asynchronous Z80 bus and request lines
    logic           r_m1_n;
    logic           r_iorq_n;
    logic           r_rd_n;
    logic [7:0]     r_di;
    logic [NCH-1:0] r_inti;
    logic [NCH-1:0] r_inti_d;

    logic           r_ack_d;
    logic           r_fetch_d;
    logic [7:0]     r_op;
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_ius;
    logic           r_int_n;
    logic           r_vec_oe;
    logic [7:0]     r_vec_do;
    logic           r_ed;
    logic           r_cb;

    logic [NCH:0]   w_ie;
    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_win;
    logic [NCH-1:0] w_reti_sel;
    logic [7:0]     w_win_vec;
    logic           w_ack_lvl;
    logic           w_ack;
    logic           w_take;
    logic           w_fetch;
    logic           w_op_done;
    logic           w_reti;
    logic [NCH-1:0] w_take_oh;
    logic [NCH-1:0] w_reti_oh;
    logic [NCH-1:0] w_pend_set;

    function automatic logic [7:0] vec_of(input int idx);
        int v;
        v = int'(VEC_BASE) + idx * VEC_STRIDE;
        return v[7:0];
    endfunction

    // While an ED prefix is outstanding, pending channels stop blocking so the
    // following 4D reaches the in-service channel further down the chain.
    always_comb begin
        w_ie    = '0;
        w_ie[0] = IEI;
        for (int i = 0; i < NCH; i++) begin
            w_ie[i+1] = w_ie[i] & ~(r_ius[i] | (r_pend[i] & ~r_ed));
        end
    end

    assign w_req = w_ie[NCH-1:0] & r_pend & ~r_ius;

    always_comb begin
        w_win      = '0;
        w_win_vec  = '0;
        w_reti_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win     = '0;
                w_win[i]  = 1'b1;
                w_win_vec = vec_of(i);
            end
            if (r_ius[i] && w_ie[i]) begin
                w_reti_sel    = '0;
                w_reti_sel[i] = 1'b1;
            end
        end
    end

    assign w_ack_lvl  = ~r_m1_n & ~r_iorq_n;
    assign w_ack      = w_ack_lvl & ~r_ack_d;
    assign w_take     = w_ack & (|w_req);
    assign w_fetch    = ~r_m1_n & ~r_rd_n & r_iorq_n;
    assign w_op_done  = r_fetch_d & ~w_fetch;
    assign w_reti     = w_op_done & r_ed & (r_op == c_OP_4D);
    assign w_take_oh  = w_take ? w_win : '0;
    assign w_reti_oh  = w_reti ? w_reti_sel : '0;
    assign w_pend_set = r_inti & ~r_inti_d & INTEN & {NCH{r_m1_n}};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_m1_n    <= 1'b1;
            r_iorq_n  <= 1'b1;
            r_rd_n    <= 1'b1;
            r_di      <= '0;
            r_inti    <= '0;
            r_inti_d  <= '0;
            r_ack_d   <= 1'b0;
            r_fetch_d <= 1'b0;
            r_op      <= '0;
            r_pend    <= '0;
            r_ius     <= '0;
            r_int_n   <= 1'b1;
            r_vec_oe  <= 1'b0;
            r_vec_do  <= '0;
            r_ed      <= 1'b0;
            r_cb      <= 1'b0;
        end else begin
            r_m1_n    <= M1_n;
            r_iorq_n  <= IORQ_n;
            r_rd_n    <= RD_n;
            r_di      <= DI;
            r_inti    <= INTI;
            r_inti_d  <= r_inti;
            r_ack_d   <= w_ack_lvl;
            r_fetch_d <= w_fetch;
            if (w_fetch) begin
                r_op <= r_di;
            end
            r_pend  <= ((r_pend & ~w_take_oh) | w_pend_set) & INTEN;
            r_ius   <= (r_ius | w_take_oh) & ~w_reti_oh;
            r_int_n <= ~|w_req;
            if (w_take) begin
                r_vec_oe <= 1'b1;
                r_vec_do <= w_win_vec;
            end else if (r_vec_oe && (r_m1_n || r_iorq_n)) begin
                r_vec_oe <= 1'b0;
            end
            // CB-prefixed ED is an ordinary opcode byte, not a prefix
            if (w_op_done) begin
                r_cb <= (r_op == c_OP_CB);
                r_ed <= (r_op == c_OP_ED) && !r_cb;
            end
        end
    end

    assign IEO    = w_ie[NCH];
    assign INT_n  = r_int_n;
    assign VEC_OE = r_vec_oe;
    assign VEC_DO = r_vec_do;
    assign IUS    = r_ius;

endmodule
`default_nettype wire
